// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and slave FSM state type
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_state_e;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB-Lite slave-side bus bundle
interface ahb_slave_mem_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_byte_lanes.sv
// rtl/ahb_byte_lanes.sv - little-endian byte-lane enables and alignment check
module ahb_byte_lanes
    import ahb_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic [3:0] lane_en,
    output logic       align_err
);

    // Lane decode; sizes wider than a word are flagged as errors too
    always_comb begin
        lane_en   = 4'b0000;
        align_err = 1'b0;
        case (size)
            HSIZE_BYTE: lane_en = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                align_err = addr_lo[0];
            end
            HSIZE_WORD: begin
                lane_en   = 4'b1111;
                align_err = (addr_lo != 2'b00);
            end
            default: align_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB-Lite memory slave with wait states and ERROR responses
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahb_slave_mem_if.slave bus
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

    logic [31:0]   mem [DEPTH];

    ahb_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [3:0]    lanes_q, lanes_d;
    logic [31:0]   hrdata_q, hrdata_d;
    logic          hreadyout_q, hreadyout_d;
    logic          hresp_q, hresp_d;

    logic [3:0]    lane_en;
    logic          align_err;
    logic          addr_err;
    logic          accept;
    logic          write_done;
    logic          load_rd;
    logic [AW-1:0] haddr_idx;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    ahb_byte_lanes u_lanes (
        .addr_lo   (bus.HADDR[1:0]),
        .size      (bus.HSIZE),
        .lane_en   (lane_en),
        .align_err (align_err)
    );

    assign haddr_idx  = bus.HADDR[AW+1:2];
    assign addr_err   = (bus.HADDR[31:AW+2] != BASE_ADDR[31:AW+2]);
    assign accept     = bus.HSEL && bus.HREADY &&
                        (bus.HTRANS != HTRANS_IDLE) && (bus.HTRANS != HTRANS_BUSY);
    assign write_done = (state_q == ST_DATA) && write_q;

    // Next-state: a new transfer may only start from a state that drives HREADYOUT high
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        lanes_d = lanes_q;
        load_rd = 1'b0;
        rd_idx  = addr_q;
        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                    load_rd = !write_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (accept) begin
                    addr_d  = haddr_idx;
                    write_d = bus.HWRITE;
                    lanes_d = lane_en;
                    if (align_err || addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_DATA;
                        load_rd = !bus.HWRITE;
                        rd_idx  = haddr_idx;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    // Read data: a write finishing on the same edge to the same word is merged in
    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < 4; i++) begin
            if (write_done && lanes_q[i] && (addr_q == rd_idx)) begin
                rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
            end
        end
        hrdata_d = load_rd ? rd_word : hrdata_q;
    end

    // FSM and registered bus outputs
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            lanes_q     <= 4'b0000;
            hrdata_q    <= 32'h0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            lanes_q     <= lanes_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Memory write at the end of the DATA cycle; reset drops an in-flight write
    always_ff @(posedge HCLK) begin
        if (HRESETn && write_done) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_q[i]) begin
                    mem[addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign bus.HRDATA    = hrdata_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - two-slave AHB-Lite bench for ahb_slave_mem
module tb_ahb_slave_mem;

    typedef struct {
        bit          tgt;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        bit          chk;
        bit          exp_err;
        logic [31:0] exp_rd;
    } xfer_t;

    logic        clk;
    logic        rstn;
    logic        tgt;
    logic        dsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        bus_ready;
    logic        bus_resp;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;

    logic [7:0]  mdl [2][1024];
    logic [31:0] exp_hr [2];
    xfer_t       q [$];
    xfer_t       tbl [25];

    ahb_slave_mem_if bus0 ();
    ahb_slave_mem_if bus1 ();

    assign bus0.HSEL   = (tgt == 1'b0);
    assign bus1.HSEL   = (tgt == 1'b1);
    assign bus0.HADDR  = haddr;
    assign bus1.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus1.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus1.HSIZE  = hsize;
    assign bus0.HWDATA = hwdata;
    assign bus1.HWDATA = hwdata;
    assign bus0.HREADY = bus_ready;
    assign bus1.HREADY = bus_ready;

    assign bus_ready = dsel ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign bus_resp  = dsel ? bus1.HRESP     : bus0.HRESP;
    assign bus_rdata = dsel ? bus1.HRDATA    : bus0.HRDATA;

    ahb_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rstn), .bus(bus0)
    );

    ahb_slave_mem #(.DEPTH(64), .BASE_ADDR(32'h0000_4000), .WAIT_STATES(2)) u_dut1 (
        .HCLK(clk), .HRESETn(rstn), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-phase slave select for the HREADY/HRDATA/HRESP return mux
    always @(posedge clk) begin
        if (!rstn) dsel <= 1'b0;
        else if (bus_ready) dsel <= tgt;
    end

    function automatic logic [31:0] base_of(bit t);
        return t ? 32'h0000_4000 : 32'h0000_0000;
    endfunction

    function automatic int bytes_of(bit t);
        return t ? 256 : 1024;
    endfunction

    function automatic int ws_of(bit t);
        return t ? 2 : 0;
    endfunction

    function automatic bit mdl_err(bit t, logic [31:0] a, logic [2:0] s);
        logic [31:0] off;
        off = a - base_of(t);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
        return off >= 32'(bytes_of(t));
    endfunction

    function automatic logic [31:0] mdl_word(bit t, logic [31:0] a);
        int off;
        off = int'((a - base_of(t)) & ~32'd3);
        return {mdl[t][off+3], mdl[t][off+2], mdl[t][off+1], mdl[t][off]};
    endfunction

    function automatic void mdl_write(bit t, logic [31:0] a, logic [2:0] s, logic [31:0] wd);
        int off;
        for (int k = 0; k < (1 << s); k++) begin
            off = int'(a - base_of(t)) + k;
            mdl[t][off] = wd[8*(off % 4) +: 8];
        end
    endfunction

    function automatic xfer_t mk(bit t, bit wr, logic [31:0] a, logic [2:0] s, logic [1:0] tr,
                                 logic [31:0] wd, bit chk, bit e, logic [31:0] rd);
        xfer_t x;
        x.tgt = t; x.wr = wr; x.addr = a; x.size = s; x.trans = tr; x.wdata = wd;
        x.chk = chk; x.exp_err = e; x.exp_rd = rd;
        return x;
    endfunction

    function automatic xfer_t rnd_xfer();
        xfer_t x;
        bit t;
        t = 1'($urandom_range(0, 1));
        x = mk(t, 1'($urandom_range(0, 1)), 32'h0, 3'd0, 2'b10, $urandom, 1'b0, 1'b0, 32'h0);
        x.size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr = base_of(t) + 32'($urandom_range(0, bytes_of(t) - 1));
        if ($urandom_range(0, 3) != 0 && x.size <= 3'd2) x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        if ($urandom_range(0, 15) == 0) x.addr = x.addr ^ 32'(bytes_of(t));
        if ($urandom_range(0, 31) == 0) x.addr = x.addr ^ 32'h0001_0000;
        x.trans = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (xfer %0d) actual=%0h required=%0h", name, n_xfer, act, exp);
        end
    endtask

    task automatic complete(input xfer_t x, input int stalls, input bit rf, input bit rl,
                            input logic [31:0] rd);
        bit e;
        e = x.chk ? x.exp_err : mdl_err(x.tgt, x.addr, x.size);
        if (!e && x.wr) mdl_write(x.tgt, x.addr, x.size, x.wdata);
        if (!e && !x.wr) exp_hr[x.tgt] = x.chk ? x.exp_rd : mdl_word(x.tgt, x.addr);
        check("stalls", 32'(stalls), 32'(e ? 1 : ws_of(x.tgt)));
        check("resp", 32'({rf, rl}), 32'({e, e}));
        check("hrdata", rd, exp_hr[x.tgt]);
        n_xfer++;
    endtask

    task automatic present(int idx);
        if (idx < q.size()) begin
            tgt    = q[idx].tgt;
            haddr  = q[idx].addr;
            hwrite = q[idx].wr;
            hsize  = q[idx].size;
            htrans = q[idx].trans;
        end else begin
            htrans = 2'b00;
        end
    endtask

    // Pipelined master: address phase of the next transfer overlaps the current data phase
    task automatic run_queue();
        int    idx, stalls, cyc, limit;
        bit    dp_v, first, r_first, rdy, nv;
        xfer_t dp, nx;
        idx = 0; stalls = 0; cyc = 0; dp_v = 0; first = 0; r_first = 0; nv = 0;
        limit = 4 * q.size() + 20;
        present(idx);
        while (idx < q.size() || dp_v) begin
            @(negedge clk);
            cyc++;
            if (cyc > limit) begin
                total++; bad++;
                $display("FAIL timeout after %0d cycles", cyc);
                break;
            end
            rdy = bus_ready;
            if (dp_v) begin
                if (first) r_first = bus_resp;
                first = 0;
                if (!rdy) stalls++;
                else complete(dp, stalls, r_first, bus_resp, bus_rdata);
            end
            nv = 0;
            if (rdy && idx < q.size()) begin
                nx  = q[idx];
                nv  = nx.trans[1];
                idx++;
            end
            @(posedge clk); #1;
            if (rdy) begin
                dp_v   = nv;
                if (nv) dp = nx;
                stalls = 0;
                first  = 1;
                hwdata = (nv && nx.wr) ? nx.wdata : 32'h0;
                present(idx);
            end
        end
        q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_hreadyout0", 32'(bus0.HREADYOUT), 32'd1);
        check("rst_hresp0", 32'(bus0.HRESP), 32'd0);
        check("rst_hrdata0", bus0.HRDATA, 32'h0);
        check("rst_hreadyout1", 32'(bus1.HREADYOUT), 32'd1);
        check("rst_hresp1", 32'(bus1.HRESP), 32'd0);
        check("rst_hrdata1", bus1.HRDATA, 32'h0);
    endtask

    initial begin
        rstn = 1'b0; tgt = 1'b0; haddr = 32'h0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
        exp_hr[0] = 32'h0; exp_hr[1] = 32'h0;

        tbl[0]  = mk(0, 1, 32'h10,   3'd2, 2'b10, 32'hDEADBEEF, 1, 0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h10,   3'd2, 2'b10, 32'h0,        1, 0, 32'hDEADBEEF);
        tbl[2]  = mk(0, 1, 32'h11,   3'd0, 2'b10, 32'h0000AB00, 1, 0, 32'h0);
        tbl[3]  = mk(0, 0, 32'h0,    3'd2, 2'b00, 32'h0,        1, 0, 32'h0);
        tbl[4]  = mk(0, 0, 32'h10,   3'd2, 2'b10, 32'h0,        1, 0, 32'hDEADABEF);
        tbl[5]  = mk(0, 1, 32'h20,   3'd2, 2'b10, 32'h12345678, 1, 0, 32'h0);
        tbl[6]  = mk(0, 0, 32'h20,   3'd2, 2'b10, 32'h0,        1, 0, 32'h12345678);
        tbl[7]  = mk(0, 0, 32'h02,   3'd2, 2'b10, 32'h0,        1, 1, 32'h0);
        tbl[8]  = mk(0, 1, 32'h20,   3'd3, 2'b10, 32'hFFFFFFFF, 1, 1, 32'h0);
        tbl[9]  = mk(0, 0, 32'h20,   3'd2, 2'b10, 32'h0,        1, 0, 32'h12345678);
        tbl[10] = mk(0, 0, 32'h400,  3'd2, 2'b10, 32'h0,        1, 1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tbl[11+k] = mk(1, 1, 32'h4030 + 32'(4*k), 3'd2, (k == 0) ? 2'b10 : 2'b11,
                           32'hCAFE0030 + 32'(4*k), 1, 0, 32'h0);
            tbl[15+k] = mk(1, 0, 32'h4030 + 32'(4*k), 3'd2, (k == 0) ? 2'b10 : 2'b11,
                           32'h0, 1, 0, 32'hCAFE0030 + 32'(4*k));
        end
        tbl[19] = mk(1, 0, 32'h4100, 3'd2, 2'b10, 32'h0,        1, 1, 32'h0);
        tbl[20] = mk(1, 1, 32'h4000, 3'd2, 2'b10, 32'h11223344, 1, 0, 32'h0);
        tbl[21] = mk(1, 1, 32'h4002, 3'd1, 2'b10, 32'hBEEF0000, 1, 0, 32'h0);
        tbl[22] = mk(1, 0, 32'h4000, 3'd2, 2'b10, 32'h0,        1, 0, 32'hBEEF3344);
        tbl[23] = mk(1, 1, 32'h4001, 3'd1, 2'b10, 32'h0,        1, 1, 32'h0);
        tbl[24] = mk(0, 0, 32'h11,   3'd0, 2'b10, 32'h0,        1, 0, 32'hDEADABEF);

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;

        // Known contents everywhere so later reads have a defined expectation
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < bytes_of(1'(t)) / 4; i++) begin
                q.push_back(mk(1'(t), 1, base_of(1'(t)) + 32'(4*i), 3'd2, 2'b10, $urandom, 0, 0, 32'h0));
            end
        end
        run_queue();

        for (int i = 0; i < 25; i++) q.push_back(tbl[i]);
        run_queue();
        @(negedge clk);
        check("idle_hready", 32'(bus_ready), 32'd1);
        check("idle_hresp", 32'(bus_resp), 32'd0);
        @(posedge clk); #1;

        // Reset during the wait states of a write: write is dropped, memory kept
        tgt = 1'b1; haddr = 32'h4030; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'hBAD0BAD0; rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        exp_hr[0] = 32'h0; exp_hr[1] = 32'h0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        q.push_back(mk(1, 0, 32'h4030, 3'd2, 2'b10, 32'h0, 1, 0, 32'hCAFE0030));
        run_queue();

        repeat (300) q.push_back(rnd_xfer());
        run_queue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite memory-mapped slave: the responder end of the bus driven by the team's AHB master. It decodes address/control phases and completes reads and writes into an internal word-organised register memory. It also inserts a programmable number of wait states and returns two-cycle ERROR responses for illegal accesses. One instance sits behind each HSELn/HREADYn pair.

## Interface
- DEPTH, 256: memory depth in 32-bit words; power of two, 4..4096.
- BASE_ADDR, 32'h0000_0000: window base; must be aligned to DEPTH*4.
- WAIT_STATES, 0: HREADYOUT-low cycles per OKAY data phase, 0..15.

- HCLK  in  1  clock; all logic on the rising edge.
- HRESETn  in  1  reset; synchronous and active-low.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 half, 010 word; anything else is illegal.
- HREADY  in  1  bus-level ready (muxed HREADYOUT of the active slave).
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  this slave's ready; goes to the master's HREADYn.
- HRESP  out  1  0 OKAY, 1 ERROR.

## Operation
- Accept: HSEL & HREADY & HTRANS[1] on a rising edge. On accept, register addr, write, size and the error flag. IDLE, BUSY or !HSEL never accepts and gives a zero-wait OKAY.
- Error when any of the following holds:
  - HSIZE > 010;
  - HSIZE=001 and HADDR[0]=1;
  - HSIZE=010 and HADDR[1:0]≠0;
  - HADDR[31:log2(DEPTH)+2] ≠ BASE_ADDR[31:log2(DEPTH)+2].
- Byte lanes are little-endian. A byte access uses lane HADDR[1:0]. A half access uses lanes {1,0} or {3,2} per HADDR[1]. A word access uses all four lanes. Only enabled lanes of HWDATA are written.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0; counter runs down.
  - DATA: HREADYOUT=1, HRESP=0; transfer completes.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- FSM transitions:
  - On accept with error: go to ERR1, then ERR2.
  - On accept with WAIT_STATES=0: go to DATA.
  - On accept with WAIT_STATES>0: go to WAIT for exactly WAIT_STATES cycles, then DATA.
  - From DATA or ERR2: go to the next accepted transfer's first state, else IDLE.
- Writes: memory updates on the edge that ends the DATA cycle, using HWDATA sampled then. An errored write never modifies memory.
- Reads: HRDATA is registered and loaded on the edge entering DATA. It holds its value at all other times. Errored reads leave HRDATA unchanged.
- Read-after-write forwarding: if a write completes on the same edge that loads HRDATA for a read of the same word, HRDATA = old word with the written lanes replaced by HWDATA.
- Bursts are handled beat-by-beat; SEQ is treated identically to NONSEQ. HBURST, HPROT and HMASTLOCK are not ported.
- In ERR1, HREADY is low, so nothing is accepted. In ERR2, a transfer presented with HREADY high is accepted normally.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0.
- Reset is sampled every edge and overrides any state: an in-flight write is dropped and an in-flight read is abandoned. Memory contents are not cleared.
- OKAY data phase lasts WAIT_STATES+1 cycles. HREADYOUT is low for the first WAIT_STATES cycles and high for the last.
- ERROR data phase always lasts 2 cycles (0/1 then 1/1), independent of WAIT_STATES.
- Pipelined back-to-back transfers with WAIT_STATES=0 sustain one transfer per cycle.
- HREADYOUT and HRESP are registered outputs; there is no combinational path from inputs to outputs.

## Structure
- Shared package ahb_pkg:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE codes BYTE/HALF/WORD;
  - HRESP codes OKAY/ERROR;
  - FSM state encoding IDLE/WAIT/DATA/ERR1/ERR2.
- Sub-module ahb_byte_lanes, combinational: (HADDR[1:0], HSIZE) in; 4-bit lane enable and alignment-error flag out. It is shared with future slaves.
- The memory array is inferred in ahb_slave_mem with per-lane write enables.

## Test plan
- Reset: hold HRESETn=0 for 2 cycles mid-transfer -> HREADYOUT=1, HRESP=0, HRDATA=0 the cycle after release.
- Word write then read (WAIT_STATES=0): write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF. Each data phase is 1 cycle with HREADYOUT=1.
- Byte write: HSIZE=000, addr 0x11, HWDATA=0x0000AB00 over 0xDEADBEEF -> read of 0x10 returns 0xDEADABEF.
- Forwarding: write word 0x12345678 to 0x20 immediately followed by a NONSEQ read of 0x20 -> HRDATA=0x12345678 in the read data phase, no stall.
- Wait states: WAIT_STATES=2, INCR4 writes 0x30..0x3C then reads back -> each beat shows HREADYOUT 0,0,1; 12 cycles per burst; data matches.
- Errors:
  - word read at 0x02 -> HREADYOUT/HRESP = 0/1 then 1/1, then IDLE.
  - HSIZE=011 write -> same 0/1 then 1/1 response; memory unchanged.
  - address BASE_ADDR+DEPTH*4 -> same ERROR response.
